// File: rtl/avalon_ram_pipelined.sv
// Avalon-MM single-port RAM slave: byte lanes, READ_LATENCY-deep read pipeline, sticky range error.
// Optional post-reset zeroing sweep selected by the macro AVALON_RAM_CLEAR_ON_RESET_EN.
module avalon_ram_pipelined #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 13,
  parameter int    DEPTH        = 5000,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "HELLO_ram.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    rangeerr
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic                  in_range;
  logic                  req_accept;
  logic                  accept_rd;
  logic                  accept_wr;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [LANES-1:0]      wr_be;
  logic [DATA_WIDTH-1:0] rd_raw;
  logic                  rangeerr_reg;

  assign in_range   = {1'b0, address} < DEPTH_L;
  assign req_accept = chipselect & (read | write) & ~waitrequest & clken;
  // A simultaneous read+write is treated as a write only.
  assign accept_rd  = req_accept & read & ~write;
  assign accept_wr  = req_accept & write & in_range;
  assign rd_idx     = in_range ? address : '0;

`ifdef AVALON_RAM_CLEAR_ON_RESET_EN
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH - 1);

  logic [0:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
  logic                  sweep_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (state_reg == ST_CLEAR && clken) begin
      if (cnt_reg == LAST_WORD) begin
        state_next = ST_READY;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  assign sweep_wr    = (state_reg == ST_CLEAR) & clken & ~reset;
  assign waitrequest = (state_reg == ST_CLEAR) | ~clken;
  assign wr_en       = sweep_wr | accept_wr;
  assign wr_addr     = sweep_wr ? cnt_reg : address;
  assign wr_data     = sweep_wr ? '0 : writedata;
  assign wr_be       = sweep_wr ? '1 : byteenable;
`else
  assign waitrequest = ~clken;
  assign wr_en       = accept_wr;
  assign wr_addr     = address;
  assign wr_data     = writedata;
  assign wr_be       = byteenable;
`endif

  // One 8-bit wide RAM per byte lane keeps each lane a plain single-writer array.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q_reg;
      always_ff @(posedge clk) begin
        if (clken) begin
          if (wr_en && wr_be[gi]) begin
            mem[wr_addr] <= wr_data[gi*8 +: 8];
          end
          q_reg <= mem[rd_idx];
        end
      end
      assign rd_raw[gi*8 +: 8] = q_reg;
    end
  endgenerate

  // Stage 0 is the RAM output register; later stages are plain delay registers.
  generate
    for (gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
      logic                  vld_reg;
      logic [DATA_WIDTH-1:0] stage_dat;
      if (gi == 0) begin : g_first
        logic oor_reg;
        always_ff @(posedge clk) begin
          if (reset) begin
            vld_reg <= 1'b0;
            oor_reg <= 1'b0;
          end else if (clken) begin
            vld_reg <= accept_rd;
            oor_reg <= ~in_range;
          end
        end
        assign stage_dat = oor_reg ? '0 : rd_raw;
      end else begin : g_next
        logic [DATA_WIDTH-1:0] dat_reg;
        always_ff @(posedge clk) begin
          if (reset) begin
            vld_reg <= 1'b0;
          end else if (clken) begin
            vld_reg <= g_stage[gi-1].vld_reg;
          end
        end
        always_ff @(posedge clk) begin
          if (clken) begin
            dat_reg <= g_stage[gi-1].stage_dat;
          end
        end
        assign stage_dat = dat_reg;
      end
    end
  endgenerate

  // Gating with clken turns a held final stage into a single pulse.
  assign readdatavalid = g_stage[READ_LATENCY-1].vld_reg & clken;
  assign readdata      = readdatavalid ? g_stage[READ_LATENCY-1].stage_dat : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rangeerr_reg <= 1'b0;
    end else if (req_accept && !in_range) begin
      rangeerr_reg <= 1'b1;
    end
  end
  assign rangeerr = rangeerr_reg;

endmodule

// File: tb/tb_avalon_ram_pipelined.sv
// Directed bench for avalon_ram_pipelined: latency-1 and latency-3 instances share one bus.
// Build with AVALON_RAM_CLEAR_ON_RESET_EN defined to exercise the zeroing sweep (DEPTH=16).
module tb_avalon_ram_pipelined;
`ifdef AVALON_RAM_CLEAR_ON_RESET_EN
  localparam int TB_DEPTH = 16;
  localparam logic SWEEP = 1'b1;
`else
  localparam int TB_DEPTH = 5000;
  localparam logic SWEEP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [12:0] address = '0;
  logic [3:0]  byteenable = '0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        clken = 1'b1;
  logic [31:0] rd1, rd3;
  logic        rv1, rv3, wr1, wr3, re1, re3;
  int          vec_cnt = 0;
  int          err_cnt = 0;

  always #5 clk = ~clk;

  avalon_ram_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(13), .DEPTH(TB_DEPTH),
                         .READ_LATENCY(1), .INIT_FILE("")) u_dut1 (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(rd1), .readdatavalid(rv1), .waitrequest(wr1),
    .rangeerr(re1));

  avalon_ram_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(13), .DEPTH(TB_DEPTH),
                         .READ_LATENCY(3), .INIT_FILE("")) u_dut3 (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(rd3), .readdatavalid(rv3), .waitrequest(wr3),
    .rangeerr(re3));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Checks both instances' valid/data against the expected single-read schedule.
  task automatic chk_out(input string tag, input logic e1, input logic [31:0] d1,
                         input logic e3, input logic [31:0] d3);
    check_val({tag, " v1"}, {31'b0, rv1}, {31'b0, e1});
    check_val({tag, " d1"}, rd1, e1 ? d1 : 32'h0);
    check_val({tag, " v3"}, {31'b0, rv3}, {31'b0, e3});
    check_val({tag, " d3"}, rd3, e3 ? d3 : 32'h0);
  endtask

  task automatic wr_word(input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d; byteenable = be;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; byteenable = '0;
    $display("write addr %0d data %h be %b", a, d, be);
  endtask

  task automatic rd_check(input logic [12:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      chipselect = 1'b0; read = 1'b0;
      chk_out($sformatf("%s t%0d", tag, t), t == 1, exp, t == 3, exp);
    end
    $display("read  addr %0d expect %h", a, exp);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while ((wr1 || wr3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, {31'b0, wr1 | wr3}, 32'h0);
  endtask

  // Called at a negedge: drops reset and counts cycles with waitrequest high.
  task automatic sweep_len(input string tag);
    int n = 0;
    reset = 1'b0;
    while (wr1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 32'(n), 32'd16);
    check_val({tag, " wr3"}, {31'b0, wr3}, 32'h0);
    $display("sweep waitrequest cycles %0d", n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst rd1", rd1, 32'h0);
    check_val("rst rv1", {31'b0, rv1}, 32'h0);
    check_val("rst re1", {31'b0, re1}, 32'h0);
    check_val("rst wr1", {31'b0, wr1}, {31'b0, SWEEP});
    check_val("rst rd3", rd3, 32'h0);
    check_val("rst rv3", {31'b0, rv3}, 32'h0);
    check_val("rst wr3", {31'b0, wr3}, {31'b0, SWEEP});
`ifdef AVALON_RAM_CLEAR_ON_RESET_EN
    sweep_len("sweep0");
`else
    reset = 1'b0;
`endif
    wait_ready("ready0");

    wr_word(13'd5, 32'hDEADBEEF, 4'b1111);
    rd_check(13'd5, 32'hDEADBEEF, "rd5");
    wr_word(13'd5, 32'h00001122, 4'b0011);
    rd_check(13'd5, 32'hDEAD1122, "lanes");

    // read and write together: write wins, no readdatavalid
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 13'd6;
    writedata = 32'h0BADF00D; byteenable = 4'b1111;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      chipselect = 1'b0; read = 1'b0; write = 1'b0; byteenable = '0;
      chk_out($sformatf("rw t%0d", t), 1'b0, 32'h0, 1'b0, 32'h0);
    end
    $display("read+write addr 6 data 0badf00d");
    rd_check(13'd6, 32'h0BADF00D, "rw rd6");

    for (int i = 0; i < 4; i++) wr_word(13'(i), 32'(i), 4'b1111);
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      chk_out($sformatf("b2b t%0d", t), t >= 1 && t <= 4, 32'(t - 1),
              t >= 3 && t <= 6, 32'(t - 3));
      if (t < 4) begin
        chipselect = 1'b1; read = 1'b1; address = 13'(t);
      end else begin
        chipselect = 1'b0; read = 1'b0;
      end
    end
    $display("back-to-back reads addr 0..3");

    check_val("re before", {30'b0, re1, re3}, 32'h0);
    wr_word(13'(TB_DEPTH - 1), 32'h12345678, 4'b1111);
    wr_word(13'(TB_DEPTH), 32'hFFFFFFFF, 4'b1111);
    check_val("re after wr", {30'b0, re1, re3}, 32'h3);
    rd_check(13'(TB_DEPTH), 32'h0, "oor");
    rd_check(13'(TB_DEPTH - 1), 32'h12345678, "last");
    check_val("re sticky", {30'b0, re1, re3}, 32'h3);

    // clken low for 3 cycles with reads of addr 2 and 3 in flight
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      chipselect = (t < 2); read = (t < 2); address = 13'(2 + t);
      clken = !(t >= 2 && t <= 4);
      #1;
      chk_out($sformatf("stall t%0d", t), t == 1 || t == 5, (t == 1) ? 32'd2 : 32'd3,
              t == 6 || t == 7, (t == 6) ? 32'd2 : 32'd3);
      check_val($sformatf("stall wr t%0d", t), {31'b0, wr1}, {31'b0, t >= 2 && t <= 4});
    end
    chipselect = 1'b0; read = 1'b0; clken = 1'b1;
    $display("clken stall of 3 cycles");

    // reset while a read of addr 5 is in flight
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = 13'd5;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      chipselect = 1'b0; read = 1'b0; reset = 1'b1;
      chk_out($sformatf("rstfly t%0d", t), t == 1, 32'hDEAD1122, 1'b0, 32'h0);
    end
    $display("reset with read in flight");
`ifdef AVALON_RAM_CLEAR_ON_RESET_EN
    reset = 1'b0;
    repeat (7) @(negedge clk);
    check_val("sweep mid wr", {31'b0, wr1}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    sweep_len("sweep restart");
    check_val("re cleared", {30'b0, re1, re3}, 32'h0);
    for (int i = 0; i < TB_DEPTH; i++) rd_check(13'(i), 32'h0, $sformatf("zero%0d", i));
`else
    reset = 1'b0;
    @(negedge clk);
    check_val("re cleared", {30'b0, re1, re3}, 32'h0);
    rd_check(13'd5, 32'hDEAD1122, "post rst");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
